pow2_normalizer: RTL and testbench

Sequential front-end for the 8-bit power-of-two logarithm stage. It accepts an arbitrary unsigned number over a valid/ready handshake and finds its most significant set bit by iterative left shifting. It emits that bit isolated as a power of two, which is the only input form the logarithm stage accepts. It also flags exact powers of two and zero inputs, so downstream logic can tell a true log2 from a floored one.

---
 rtl/pow2_pkg.sv | 14 +
 rtl/pow2_normalizer.sv | 96 +++++++++
 tb/tb_pow2_normalizer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pow2_pkg.sv
// Shared definitions for the power-of-two normalizer and the logarithm stage.
//   state_t    : normalizer FSM states
//   POW2_WIDTH : default data width shared by the normalizer and log2 stage
package pow2_pkg;

  localparam int POW2_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pow2_normalizer.sv
// Sequential MSB isolator feeding the power-of-two logarithm stage.
// Accepts an unsigned number, shifts it left one bit per cycle until the top
// bit is set, and reports the isolated MSB as a one-hot value. Also flags
// exact powers of two and zero inputs.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake (ready only while idle)
//   in_number             : unsigned value to normalize
//   out_valid/out_ready   : result handshake (valid held until consumed)
//   out_number            : isolated MSB, one-hot or zero
//   out_exact             : input was a nonzero power of two
//   out_zero              : input was zero
module pow2_normalizer
  import pow2_pkg::*;
#(
  parameter int WIDTH = POW2_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_number,
  output logic             out_exact,
  output logic             out_zero
);

  localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] k;
  logic             exact_q;
  logic             exact_in;

  // x is a power of two iff it is nonzero and clearing its lowest set bit
  // leaves nothing behind.
  assign exact_in = (in_number != '0) && ((in_number & (in_number - 1'b1)) == '0);
  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      work       <= '0;
      k          <= '0;
      exact_q    <= 1'b0;
      out_valid  <= 1'b0;
      out_number <= '0;
      out_exact  <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work    <= in_number;
            k       <= '0;
            exact_q <= exact_in;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (work == '0) begin
            out_number <= '0;
            out_zero   <= 1'b1;
            out_exact  <= 1'b0;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end else if (work[WIDTH-1]) begin
            // k shifts were needed, so the MSB sat at WIDTH-1-k.
            out_number <= TOP_BIT >> k;
            out_zero   <= 1'b0;
            out_exact  <= exact_q;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            // Nonzero work reaches the top bit within WIDTH-1 shifts,
            // so k cannot wrap.
            work <= work << 1;
            k    <= k + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pow2_normalizer.sv
// Self-checking bench for pow2_normalizer: directed cases, reset abort,
// full input sweep and randomized stalls against a floor-power-of-two model.
module tb_pow2_normalizer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_number = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_number;
  logic         out_exact;
  logic         out_zero;

  int passed = 0;
  int total  = 0;

  pow2_normalizer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_number (in_number),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_number(out_number),
    .out_exact (out_exact),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Largest power of two not exceeding x, found by repeated doubling.
  function automatic int floor_pow2(input int x);
    int p;
    if (x == 0) return 0;
    p = 1;
    while (p * 2 <= x) p = p * 2;
    return p;
  endfunction

  function automatic int log2_of_pow(input int p);
    int n;
    n = 0;
    while (p > 1) begin
      p = p / 2;
      n++;
    end
    return n;
  endfunction

  // One transaction: offer x, measure latency, optionally stall the result
  // for `stall` cycles (with 0xFF offered meanwhile when `poke` is set).
  task automatic run(input logic [W-1:0] x, input int stall, input bit poke);
    int p, lat, exp_lat;
    logic [W-1:0] held;
    p       = floor_pow2(int'(x));
    exp_lat = (x == 0) ? 1 : 1 + (W - 1 - log2_of_pow(p));
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_number = x;
    out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < W + 4) begin
      step();
      lat++;
    end
    check($sformatf("latency_%02h", x), lat, exp_lat);
    check($sformatf("number_%02h", x), out_number, p);
    check($sformatf("exact_%02h", x), out_exact, (x != 0) && (p == int'(x)));
    check($sformatf("zero_%02h", x), out_zero, x == 0);
    held = out_number;
    if (poke) begin
      in_valid  = 1'b1;
      in_number = 8'hFF;
    end
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", out_valid, 1);
      check("stall_number", out_number, held);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("consumed_valid", out_valid, 0);
    check("consumed_in_ready", in_ready, 1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_number", out_number, 0);
    check("rst_exact", out_exact, 0);
    check("rst_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Directed cases
    run(8'h80, 0, 0);
    run(8'h01, 0, 0);
    run(8'h5A, 0, 0);
    run(8'h00, 0, 0);
    run(8'h13, 5, 1);           // 0xFF held during the stall, not accepted
    check("poke_still_offered", in_valid, 1);
    run(8'hFF, 0, 0);           // now accepted, yields 0x80
    in_valid = 1'b0;

    // Reset during the third SCAN cycle of 0x03
    in_valid  = 1'b1;
    in_number = 8'h03;
    step();                     // accept
    in_valid = 1'b0;
    step();                     // SCAN 1
    step();                     // SCAN 2
    rst_n = 1'b0;
    step();                     // SCAN 3 sees reset
    rst_n = 1'b1;
    check("abort_valid", out_valid, 0);
    check("abort_number", out_number, 0);
    check("abort_exact", out_exact, 0);
    check("abort_zero", out_zero, 0);
    check("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("abort_no_output", out_valid, 0);
    end
    run(8'h20, 0, 0);

    // Full sweep
    for (int v = 0; v < 256; v++) run(W'(v), 0, 0);

    // Randomized values and stalls
    for (int n = 0; n < 60; n++) run(W'($urandom_range(255)), int'($urandom_range(3)), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
